// File: rtl/reg_bank.sv
// reg_bank: 32-entry register file with two combinational read ports, one write port and A/B operand latches
// Ports: clk, reset_n (async, active-low); RegWrite/WriteReg/WriteData write port;
// ReadReg1/ReadReg2 -> ReadData1/ReadData2 combinational reads ($0 reads zero);
// ABLoad captures ReadData1/ReadData2 into A_out/B_out.
module reg_bank #(
   parameter int              DATA_W  = 32,
   parameter logic [DATA_W-1:0] SP_INIT = 227
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              RegWrite,
   input  logic [4:0]        ReadReg1,
   input  logic [4:0]        ReadReg2,
   input  logic [4:0]        WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              ABLoad,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic [DATA_W-1:0] A_out,
   output logic [DATA_W-1:0] B_out
);
   logic [DATA_W-1:0] regs [32];
   always_comb begin
      ReadData1 = ReadReg1 == 5'd0 ? '0 : regs[ReadReg1];
      ReadData2 = ReadReg2 == 5'd0 ? '0 : regs[ReadReg2];
   end
   // A/B sample the pre-edge read data, so a same-edge write is not bypassed
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= i == 29 ? SP_INIT : '0;
         A_out <= '0;
         B_out <= '0;
      end else begin
         if (RegWrite && WriteReg != 5'd0) regs[WriteReg] <= WriteData;
         if (ABLoad) begin
            A_out <= ReadData1;
            B_out <= ReadData2;
         end
      end
   end
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed self-checking bench for reg_bank
module tb_reg_bank;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        RegWrite = 1'b0;
   logic [4:0]  ReadReg1 = '0;
   logic [4:0]  ReadReg2 = '0;
   logic [4:0]  WriteReg = '0;
   logic [31:0] WriteData = '0;
   logic        ABLoad = 1'b0;
   logic [31:0] ReadData1, ReadData2, A_out, B_out;
   int          passed = 0;
   int          total = 0;

   reg_bank dut (
      .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite), .ReadReg1(ReadReg1),
      .ReadReg2(ReadReg2), .WriteReg(WriteReg), .WriteData(WriteData), .ABLoad(ABLoad),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .A_out(A_out), .B_out(B_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] r, input logic [31:0] d);
      RegWrite = 1'b1; WriteReg = r; WriteData = d;
      tick();
      RegWrite = 1'b0;
   endtask

   initial begin
      #12 reset_n = 1'b1;
      tick();
      ReadReg1 = 5'd29; ReadReg2 = 5'd5; #1;
      check("init_sp", ReadData1, 32'd227);
      check("init_r5", ReadData2, 32'd0);
      check("init_a", A_out, 32'd0);
      wr(5'd8, 32'hDEADBEEF);
      ReadReg1 = 5'd8; ReadReg2 = 5'd8; #1;
      check("wr8_p1", ReadData1, 32'hDEADBEEF);
      check("wr8_p2", ReadData2, 32'hDEADBEEF);
      ReadReg1 = 5'd7; ReadReg2 = 5'd9; #1;
      check("r7_same", ReadData1, 32'd0);
      check("r9_same", ReadData2, 32'd0);
      ReadReg1 = 5'd29; #1;
      check("sp_same", ReadData1, 32'd227);
      wr(5'd0, 32'hFFFFFFFF);
      ReadReg1 = 5'd0; #1;
      check("r0_zero", ReadData1, 32'd0);
      wr(5'd9, 32'd5);
      ReadReg1 = 5'd9; ReadReg2 = 5'd8;
      RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'd7; ABLoad = 1'b1;
      tick();
      RegWrite = 1'b0; #1;
      check("ab_old_a", A_out, 32'd5);
      check("ab_old_b", B_out, 32'hDEADBEEF);
      check("ab_new_rd", ReadData1, 32'd7);
      tick();
      ABLoad = 1'b0; #1;
      check("ab_next_a", A_out, 32'd7);
      ReadReg1 = 5'd8;
      tick();
      check("ab_hold", A_out, 32'd7);
      wr(5'd31, 32'h00000040);
      wr(5'd29, 32'd100);
      ReadReg1 = 5'd31; ReadReg2 = 5'd29; #1;
      check("ra_wr", ReadData1, 32'd64);
      check("sp_wr", ReadData2, 32'd100);
      RegWrite = 1'b0; WriteReg = 5'd3; WriteData = 32'd55;
      repeat (3) tick();
      ReadReg1 = 5'd3; #1;
      check("no_we", ReadData1, 32'd0);
      ReadReg1 = 5'd29; ReadReg2 = 5'd31;
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("rst_sp", ReadData1, 32'd227);
      check("rst_ra", ReadData2, 32'd0);
      check("rst_a", A_out, 32'd0);
      check("rst_b", B_out, 32'd0);
      RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'd99;
      tick();
      ReadReg1 = 5'd5; #1;
      check("rst_block", ReadData1, 32'd0);
      reset_n = 1'b1;
      tick();
      RegWrite = 1'b0; #1;
      check("post_rst_wr", ReadData1, 32'd99);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/reg_bank.md
# reg_bank

Register file for the multicycle datapath: 32 general registers of DATA_W bits with two combinational read ports and one synchronous write port. It also holds the A/B operand latches that feed the ALU stage. The write address comes straight from the destination-register select mux (rt, rd, $29 or $31), and the write data comes from the write-back mux. Register $0 always reads as zero; $29 ($sp) resets to a non-zero stack base.

## Interface
Parameters:
- DATA_W, 32, width of every register and data port
- SP_INIT, 227, reset value of register 29 ($sp)

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset_n  in  1  reset, asynchronous and active-low
- RegWrite  in  1  write enable for the write port
- ReadReg1  in  5  read address, port 1 (instr[25:21], rs)
- ReadReg2  in  5  read address, port 2 (instr[20:16], rt)
- WriteReg  in  5  write address, driven by the destination-register select mux output
- WriteData  in  DATA_W  write data
- ABLoad  in  1  load enable for the A/B operand latches
- ReadData1  out  DATA_W  combinational contents of ReadReg1
- ReadData2  out  DATA_W  combinational contents of ReadReg2
- A_out  out  DATA_W  latched operand A
- B_out  out  DATA_W  latched operand B

## Operation
- Storage is regs[0..31], each DATA_W bits.
- Reset (reset_n low, asynchronous, effective immediately, including mid-cycle or mid-instruction):
  - regs[29] = SP_INIT;
  - all other regs = 0;
  - A_out = B_out = 0.
  - All writes and loads are blocked while reset_n is low.
  - First update possible on the first rising clk edge after reset_n goes high.
- Write: at a rising clk edge with RegWrite = 1 and WriteReg != 0, regs[WriteReg] <= WriteData.
  - RegWrite = 1 with WriteReg = 0 is a no-op; regs[0] stays 0.
  - RegWrite = 0: no register changes, whatever WriteReg and WriteData are.
- Read: ReadDataN = (ReadRegN == 0) ? 0 : regs[ReadRegN]. The two ports are fully independent; both may address the same register.
- A/B latches: at a rising clk edge with ABLoad = 1, A_out <= ReadData1 and B_out <= ReadData2. With ABLoad = 0 they hold.
- No internal bypass:
  - ReadData reflects a write only after the edge that performs it.
  - If RegWrite and ABLoad are both 1 on the same edge, A/B capture the pre-write values.
- Writes to regs[29] and regs[31] behave like any other register; SP_INIT applies only at reset.
- Widths are exact: WriteData is stored unmodified, with no extension or truncation.

## Timing
- Read path is purely combinational: zero cycles from address or register change to ReadData.
- Write latency is 1 edge: the value is visible on ReadData immediately after the writing edge.
- A/B latency is 1 edge after ABLoad.
- A write to register R followed by ABLoad on the next edge: A/B see the new value.
- Simultaneous events on one edge:
  - write + ABLoad: old value latched, new value stored;
  - write to R while both ports read R: both ports show the new value after the edge.
- reset_n asserted between edges: all outputs take their reset values without waiting for clk. A write that would have happened on the next edge is lost.

## Test plan
- Reset state: pulse reset_n low mid-cycle -> immediately ReadData1 with ReadReg1 = 29 is 227, ReadReg1 = 5 gives 0, and A_out = B_out = 0 with no clk edge.
- Basic write/read: RegWrite = 1, WriteReg = 8, WriteData = 32'hDEADBEEF, one edge, then RegWrite = 0 -> ReadData1 and ReadData2 with ReadReg = 8 both read 32'hDEADBEEF; every other register is unchanged.
- $0 protection: RegWrite = 1, WriteReg = 0, WriteData = 32'hFFFFFFFF -> ReadData1 with ReadReg1 = 0 stays 0.
- Write/latch same edge: regs[9] = 5; on one edge RegWrite = 1 (WriteReg = 9, WriteData = 7) and ABLoad = 1 (ReadReg1 = 9) -> A_out = 5 and ReadData1 = 7. ABLoad on the next edge -> A_out = 7.
- $sp/$ra: write 31 <= 32'h00000040 and 29 <= 100 -> read back 64 and 100. Assert reset_n -> 29 reads 227 and 31 reads 0.
- RegWrite low: WriteReg = 3, WriteData = 55, RegWrite = 0 for 3 edges -> regs[3] stays 0.
